// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the program loader.
package prog_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_COLLECT,
    S_WRITE,
    S_VERIFY,
    S_DONE,
    S_ERROR
  } loader_state_t;

  localparam logic [3:0] WSTRB_WORD = 4'b1111;
  localparam logic [3:0] WSTRB_NONE = 4'b0000;

endpackage

// File: rtl/prog_loader_byte_packer.sv
// Packs four accepted bytes into a little-endian word (first byte in [7:0]).
// word/word_valid are combinational on the 4th byte so the caller can capture the word on that same edge.
module byte_packer (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        in_vld,
  input  logic [7:0]  in_dat,
  output logic [31:0] word,
  output logic        word_valid
);

  logic [1:0]  lane;
  logic [23:0] low;

  assign word_valid = in_vld && (lane == 2'd3);
  assign word       = {in_dat, low};

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      lane <= 2'd0;
      low  <= 24'd0;
    end else if (in_vld) begin
      lane <= lane + 2'd1;
      case (lane)
        2'd0:    low[7:0]   <= in_dat;
        2'd1:    low[15:8]  <= in_dat;
        2'd2:    low[23:16] <= in_dat;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/prog_loader.sv
// Program loader: byte stream -> 32-bit RAM writes over the native interface, CPU held in reset until WORD_COUNT words land.
// All outputs registered; no byte is accepted while a RAM request is open. Build option PROG_LOADER_VERIFY_EN adds read-back.
module prog_loader #(
  parameter logic [31:0] ADDR_BASE  = 32'h0000_0000,
  parameter int unsigned WORD_COUNT = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [7:0]  s_data,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata,
  output logic        bus_sel,
  output logic        cpu_hold,
  output logic        busy,
  output logic        done,
  output logic        error
);
  import prog_loader_pkg::*;

  localparam logic [16:0] LAST_IDX = 17'(WORD_COUNT - 1);

  loader_state_t state, state_nxt;
  logic [16:0]   word_idx;
  logic [31:0]   word_dat;
  logic          word_vld;
  logic          byte_fire;
  logic          mem_fire;
  logic          pack_clear;
  logic          load_base;
  logic          advance;
  logic          in_load_nxt;

  assign byte_fire  = s_valid && s_ready;
  assign mem_fire   = mem_valid && mem_ready;
  assign pack_clear = (state == S_IDLE) || (state == S_DONE) || (state == S_ERROR);

  byte_packer u_packer (
    .clk        (clk),
    .reset      (reset),
    .clear      (pack_clear),
    .in_vld     (byte_fire),
    .in_dat     (s_data),
    .word       (word_dat),
    .word_valid (word_vld)
  );

  always_comb begin
    state_nxt = state;
    advance   = 1'b0;
    load_base = (state == S_IDLE);
    case (state)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          state_nxt = S_COLLECT;
          load_base = 1'b1;
        end
      end
      S_COLLECT: begin
        if (word_vld) state_nxt = S_WRITE;
      end
`ifdef PROG_LOADER_VERIFY_EN
      S_WRITE: begin
        if (mem_fire) state_nxt = S_VERIFY;
      end
      S_VERIFY: begin
        if (mem_fire) begin
          if (mem_rdata == mem_wdata) advance = 1'b1;
          else state_nxt = S_ERROR;
        end
      end
`else
      S_WRITE: begin
        if (mem_fire) advance = 1'b1;
      end
`endif
      default: state_nxt = S_IDLE;
    endcase
    if (advance) state_nxt = (word_idx == LAST_IDX) ? S_DONE : S_COLLECT;
  end

  assign in_load_nxt = (state_nxt == S_COLLECT) || (state_nxt == S_WRITE) ||
                       (state_nxt == S_VERIFY);

  // Outputs are registered from the next state so every flag changes on the same edge as the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      s_ready   <= 1'b0;
      mem_valid <= 1'b0;
      mem_addr  <= ADDR_BASE;
      mem_wdata <= 32'd0;
      mem_wstrb <= WSTRB_NONE;
      word_idx  <= 17'd0;
      bus_sel   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      cpu_hold  <= 1'b1;
    end else begin
      state     <= state_nxt;
      s_ready   <= (state_nxt == S_COLLECT);
      mem_valid <= (state_nxt == S_WRITE) || (state_nxt == S_VERIFY);
      mem_wstrb <= (state_nxt == S_WRITE) ? WSTRB_WORD : WSTRB_NONE;
      bus_sel   <= in_load_nxt;
      busy      <= in_load_nxt;
      done      <= (state_nxt == S_DONE);
      cpu_hold  <= (state_nxt != S_DONE);
      if (word_vld) mem_wdata <= word_dat;
      if (load_base) begin
        mem_addr <= ADDR_BASE;
        word_idx <= 17'd0;
      end else if (advance) begin
        mem_addr <= mem_addr + 32'd4;
        word_idx <= word_idx + 17'd1;
      end
    end
  end

`ifdef PROG_LOADER_VERIFY_EN
  always_ff @(posedge clk) begin
    if (reset) error <= 1'b0;
    else       error <= (state_nxt == S_ERROR);
  end
`else
  logic unused_rdata;
  assign unused_rdata = ^mem_rdata;
  assign error = 1'b0;
`endif

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: table vectors, random loads against a word-packing model, and reset/wrap/verify corner sequences.
`timescale 1ns/1ps
module tb_prog_loader;

  localparam logic [31:0] BASE0 = 32'h0000_0000;
  localparam int          WC0   = 4;
  localparam logic [31:0] BASE1 = 32'hFFFF_FFF8;
  localparam int          WC1   = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        start_s[2], s_valid_s[2], s_ready_s[2], mem_valid_s[2], mem_ready_s[2];
  logic        bus_sel_s[2], cpu_hold_s[2], busy_s[2], done_s[2], error_s[2];
  logic [7:0]  s_data_s[2];
  logic [31:0] mem_addr_s[2], mem_wdata_s[2], mem_rdata_s[2];
  logic [3:0]  mem_wstrb_s[2];

  prog_loader #(.ADDR_BASE(BASE0), .WORD_COUNT(WC0)) dut0 (
    .clk(clk), .reset(reset), .start(start_s[0]),
    .s_valid(s_valid_s[0]), .s_ready(s_ready_s[0]), .s_data(s_data_s[0]),
    .mem_valid(mem_valid_s[0]), .mem_ready(mem_ready_s[0]), .mem_addr(mem_addr_s[0]),
    .mem_wdata(mem_wdata_s[0]), .mem_wstrb(mem_wstrb_s[0]), .mem_rdata(mem_rdata_s[0]),
    .bus_sel(bus_sel_s[0]), .cpu_hold(cpu_hold_s[0]), .busy(busy_s[0]),
    .done(done_s[0]), .error(error_s[0])
  );

  prog_loader #(.ADDR_BASE(BASE1), .WORD_COUNT(WC1)) dut1 (
    .clk(clk), .reset(reset), .start(start_s[1]),
    .s_valid(s_valid_s[1]), .s_ready(s_ready_s[1]), .s_data(s_data_s[1]),
    .mem_valid(mem_valid_s[1]), .mem_ready(mem_ready_s[1]), .mem_addr(mem_addr_s[1]),
    .mem_wdata(mem_wdata_s[1]), .mem_wstrb(mem_wstrb_s[1]), .mem_rdata(mem_rdata_s[1]),
    .bus_sel(bus_sel_s[1]), .cpu_hold(cpu_hold_s[1]), .busy(busy_s[1]),
    .done(done_s[1]), .error(error_s[1])
  );

  typedef struct {
    int          inst;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } wr_t;

  typedef struct {
    logic [7:0]  b0, b1, b2, b3;
    int          gap;
    int          lat;
    logic [31:0] exp_addr;
    logic [31:0] exp_data;
  } vec_t;

  wr_t         wr_q[$];
  logic [31:0] seen_addr[$];
  int          lat[2], cnt[2], rd_cnt[2], bad_rd[2];
  logic [31:0] last_wr[2];
  bit          mon_en = 1'b0;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  // RAM model: raises mem_ready after lat[i] cycles of mem_valid, logs writes, answers reads.
  initial begin
    for (int i = 0; i < 2; i++) begin
      mem_ready_s[i] = 1'b0;
      mem_rdata_s[i] = 32'd0;
      lat[i] = 1; cnt[i] = 0; rd_cnt[i] = 0; bad_rd[i] = -1;
      last_wr[i] = 32'd0;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (mem_ready_s[i]) begin
          mem_ready_s[i] = 1'b0;
          cnt[i] = 0;
        end
        if (reset) begin
          cnt[i] = 0;
        end else if (mem_valid_s[i]) begin
          if (cnt[i] >= lat[i]) begin
            mem_ready_s[i] = 1'b1;
            cnt[i] = 0;
            if (mem_wstrb_s[i] == 4'b1111) begin
              wr_q.push_back('{i, mem_addr_s[i], mem_wdata_s[i], mem_wstrb_s[i]});
              last_wr[i] = mem_wdata_s[i];
            end else begin
              mem_rdata_s[i] = (rd_cnt[i] == bad_rd[i]) ? 32'hDEAD_BEEF : last_wr[i];
              rd_cnt[i]++;
            end
          end else begin
            cnt[i]++;
          end
        end
        if (mon_en)
          chk($sformatf("invariants%0d", i),
              {29'd0, cpu_hold_s[i] ^ done_s[i], !(s_ready_s[i] && mem_valid_s[i]),
               bus_sel_s[i] == busy_s[i]}, 32'd7);
      end
    end
  end

  task automatic send_byte(input int i, input logic [7:0] b);
    int t = 0;
    s_valid_s[i] = 1'b1;
    s_data_s[i]  = b;
    while (!s_ready_s[i] && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!s_ready_s[i]) timeout_fail("s_ready");
    @(negedge clk);
    s_valid_s[i] = 1'b0;
  endtask

  task automatic pulse_start(input int i);
    start_s[i] = 1'b1;
    @(negedge clk);
    start_s[i] = 1'b0;
  endtask

  task automatic expect_write(input int i, input logic [31:0] addr, input logic [31:0] data,
                              input string tag);
    int  t = 0;
    wr_t e;
    while (wr_q.size() == 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (wr_q.size() == 0) begin
      timeout_fail(tag);
    end else begin
      e = wr_q.pop_front();
      seen_addr.push_back(e.addr);
      chk({tag, "_inst"}, e.inst, i);
      chk({tag, "_addr"}, e.addr, addr);
      chk({tag, "_data"}, e.data, data);
      chk({tag, "_wstrb"}, {28'd0, e.strb}, 32'hF);
    end
  endtask

  task automatic expect_done(input int i, input string tag);
    int t = 0;
    while (!done_s[i] && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk({tag, "_done"}, done_s[i], 1);
    chk({tag, "_cpu_hold"}, cpu_hold_s[i], 0);
    chk({tag, "_bus_sel"}, bus_sel_s[i], 0);
    chk({tag, "_busy"}, busy_s[i], 0);
    chk({tag, "_mem_valid"}, mem_valid_s[i], 0);
  endtask

  task automatic check_reset_vals(input int i, input string tag);
    chk({tag, "_s_ready"}, s_ready_s[i], 0);
    chk({tag, "_mem_valid"}, mem_valid_s[i], 0);
    chk({tag, "_mem_wdata"}, mem_wdata_s[i], 0);
    chk({tag, "_mem_wstrb"}, {28'd0, mem_wstrb_s[i]}, 0);
    chk({tag, "_mem_addr"}, mem_addr_s[i], (i == 0) ? BASE0 : BASE1);
    chk({tag, "_bus_sel"}, bus_sel_s[i], 0);
    chk({tag, "_busy"}, busy_s[i], 0);
    chk({tag, "_done"}, done_s[i], 0);
    chk({tag, "_error"}, error_s[i], 0);
    chk({tag, "_cpu_hold"}, cpu_hold_s[i], 1);
  endtask

  // Reference model: a word is its four bytes little-endian; word w goes to base + 4*w (mod 2^32).
  task automatic run_load(input int i, input int nw, input logic [31:0] base, input string tag);
    logic [7:0] b[4];
    pulse_start(i);
    for (int w = 0; w < nw; w++) begin
      lat[i] = $urandom_range(0, 3);
      for (int k = 0; k < 4; k++) b[k] = 8'($urandom_range(0, 255));
      for (int k = 0; k < 4; k++) begin
        send_byte(i, b[k]);
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      expect_write(i, base + 32'(w) * 32'd4, {b[3], b[2], b[1], b[0]},
                   $sformatf("%s_w%0d", tag, w));
    end
    expect_done(i, tag);
  endtask

  initial begin
    vec_t       tbl[8];
    logic [7:0] bb[4];
    int         t;
    bit         seen_vld;

    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      start_s[i] = 1'b0; s_valid_s[i] = 1'b0; s_data_s[i] = 8'd0;
    end
    repeat (3) @(negedge clk);
    check_reset_vals(0, "rst0");
    check_reset_vals(1, "rst1");
    reset  = 1'b0;
    mon_en = 1'b1;

    tbl[0] = '{8'h13, 8'h00, 8'h00, 8'h00, 0, 1, 32'h0000_0000, 32'h0000_0013};
    tbl[1] = '{8'h13, 8'h00, 8'h00, 8'h00, 0, 1, 32'h0000_0004, 32'h0000_0013};
    tbl[2] = '{8'h13, 8'h00, 8'h00, 8'h00, 0, 1, 32'h0000_0008, 32'h0000_0013};
    tbl[3] = '{8'h6F, 8'h00, 8'h00, 8'h00, 0, 1, 32'h0000_000C, 32'h0000_006F};
    tbl[4] = '{8'h78, 8'h56, 8'h34, 8'h12, 3, 1, 32'h0000_0000, 32'h1234_5678};
    tbl[5] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 0, 5, 32'h0000_0004, 32'hDDCC_BBAA};
    tbl[6] = '{8'h01, 8'h02, 8'h03, 8'h04, 1, 0, 32'h0000_0008, 32'h0403_0201};
    tbl[7] = '{8'hFF, 8'h00, 8'hFF, 8'h00, 2, 2, 32'h0000_000C, 32'h00FF_00FF};

    for (int r = 0; r < 8; r++) begin
      bb[0] = tbl[r].b0; bb[1] = tbl[r].b1; bb[2] = tbl[r].b2; bb[3] = tbl[r].b3;
      lat[0] = tbl[r].lat;
      if (r % 4 == 0) pulse_start(0);
      for (int k = 0; k < 4; k++) begin
        send_byte(0, bb[k]);
        if (k < 3) repeat (tbl[r].gap) @(negedge clk);
      end
      // While RAM holds off, the request must stay put and no byte may be taken.
      for (int j = 0; j < tbl[r].lat; j++) begin
        chk($sformatf("stall%0d_vld", r), mem_valid_s[0], 1);
        chk($sformatf("stall%0d_addr", r), mem_addr_s[0], tbl[r].exp_addr);
        chk($sformatf("stall%0d_wdata", r), mem_wdata_s[0], tbl[r].exp_data);
        chk($sformatf("stall%0d_s_ready", r), s_ready_s[0], 0);
        @(negedge clk);
      end
      expect_write(0, tbl[r].exp_addr, tbl[r].exp_data, $sformatf("tbl%0d", r));
      if (r % 4 == 3) expect_done(0, $sformatf("tbl_done%0d", r));
    end

    for (int n = 0; n < 3; n++) run_load(0, WC0, BASE0, $sformatf("rnd%0d", n));

    pulse_start(0);
    for (int k = 0; k < 4; k++) send_byte(0, (k == 0) ? 8'h13 : 8'h00);
    expect_write(0, BASE0, 32'h0000_0013, "mid_w0");
    send_byte(0, 8'hAA);
    send_byte(0, 8'hBB);
    reset = 1'b1;
    @(negedge clk);
    check_reset_vals(0, "mid_rst");
    reset = 1'b0;
    run_load(0, WC0, BASE0, "restart");

    seen_addr.delete();
    run_load(1, WC1, BASE1, "wrap");
    chk("wrap_count", seen_addr.size(), 3);
    if (seen_addr.size() == 3) begin
      chk("wrap_a0", seen_addr[0], 32'hFFFF_FFF8);
      chk("wrap_a1", seen_addr[1], 32'hFFFF_FFFC);
      chk("wrap_a2", seen_addr[2], 32'h0000_0000);
    end

`ifdef PROG_LOADER_VERIFY_EN
    rd_cnt[0] = 0;
    bad_rd[0] = 1;
    lat[0]    = 1;
    pulse_start(0);
    for (int k = 0; k < 4; k++) send_byte(0, 8'(k + 1));
    expect_write(0, BASE0, 32'h0403_0201, "vfy_w0");
    for (int k = 0; k < 4; k++) send_byte(0, 8'(8'h11 * (k + 1)));
    expect_write(0, BASE0 + 32'd4, 32'h4433_2211, "vfy_w1");
    t = 0;
    while (!error_s[0] && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("vfy_error", error_s[0], 1);
    chk("vfy_done", done_s[0], 0);
    chk("vfy_cpu_hold", cpu_hold_s[0], 1);
    chk("vfy_bus_sel", bus_sel_s[0], 0);
    chk("vfy_busy", busy_s[0], 0);
    seen_vld = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (mem_valid_s[0]) seen_vld = 1'b1;
    end
    chk("vfy_no_req", seen_vld, 0);
    bad_rd[0] = -1;
    run_load(0, WC0, BASE0, "vfy_recover");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
# prog_loader

Program loader for the PicoRV32-native-memory SoC. It accepts a byte stream (e.g. from a UART receiver), packs it into little-endian 32-bit words and writes them into program RAM through the native memory interface. While loading, it owns the RAM port via `bus_sel` and holds the CPU in reset. It releases the CPU once `WORD_COUNT` words are written.

## Interface
- `ADDR_BASE`, default 32'h0000_0000: byte address of the first word; must be 4-aligned.
- `WORD_COUNT`, default 256: words per load, legal range 1..65535.
- `clk`  in  1: single clock; all logic is rising-edge.
- `reset`  in  1: synchronous, active-high.
- `start`  in  1: begin a load; sampled only in IDLE, DONE and ERROR.
- `s_valid`  in  1: byte available.
- `s_ready`  out  1: loader accepts a byte.
- `s_data`  in  8: byte payload.
- `mem_valid`  out  1: native interface request.
- `mem_ready`  in  1: RAM completes the request.
- `mem_addr`  out  32: word address.
- `mem_wdata`  out  32: write data.
- `mem_wstrb`  out  4: 4'b1111 for a write, 4'b0000 for a read.
- `mem_rdata`  in  32: read data, used only with verify.
- `bus_sel`  out  1: 1 means the loader drives the RAM port; the external mux selects on it.
- `cpu_hold`  out  1: 1 means the CPU is kept in reset.
- `busy`  out  1: load in progress.
- `done`  out  1: last load completed successfully.
- `error`  out  1: verify mismatch.

## Operation
- **States:** IDLE, COLLECT, WRITE, VERIFY (verify builds only), DONE, ERROR.
- **IDLE:**
  - `start` moves to COLLECT.
  - The byte index and word index are cleared.
  - `mem_addr` is loaded with ADDR_BASE.
- **COLLECT:**
  - `s_ready`=1.
  - On each `s_valid&&s_ready`, the byte goes to lane [8k+7:8k], where k counts 0..3; the first byte lands in [7:0].
  - Idle gaps in `s_valid` are allowed.
  - After the 4th byte, the next state is WRITE.
- **WRITE:**
  - `mem_valid`=1 and `mem_wstrb`=1111; `s_ready`=0.
  - On `mem_valid&&mem_ready`, the next state is VERIFY if built, otherwise the "advance" step.
- **VERIFY:**
  - `mem_valid`=1, `mem_wstrb`=0000, same `mem_addr`.
  - On `mem_ready`, `mem_rdata` is compared with `mem_wdata`.
  - Equal: advance. Differ: go to ERROR.
- **Advance:**
  - `mem_addr` += 4, with 32-bit wrap-around.
  - Word index increments.
  - If word index reaches WORD_COUNT, go to DONE; else go to COLLECT.
- **DONE:**
  - `done`=1, `bus_sel`=0, `cpu_hold`=0, `busy`=0.
  - `start` begins a new load: `done` clears, `cpu_hold` is raised and `bus_sel` is raised, all on the same edge.
- **ERROR:**
  - `error`=1, `bus_sel`=0, `cpu_hold`=1, `busy`=0.
  - Left only by `reset` or `start`.
- `start` is ignored in COLLECT/WRITE/VERIFY.
- `busy`=`bus_sel`=1 in COLLECT, WRITE and VERIFY.

## Timing
- **Reset values:**
  - `s_ready`, `mem_valid`, `mem_wdata`, `mem_wstrb` = 0.
  - `mem_addr` = ADDR_BASE.
  - `bus_sel`, `busy`, `done`, `error` = 0.
  - `cpu_hold` = 1.
- **Reset mid-load:** the partial word is discarded and `mem_valid` drops at that edge.
- **Registered outputs:** all outputs are registered; none is combinational from any input.
- **Request rules:**
  - `mem_valid` rises the cycle after the 4th byte handshake.
  - `mem_addr`, `mem_wdata` and `mem_wstrb` stay stable while `mem_valid`=1.
  - `mem_valid` falls on the edge where `mem_ready`=1 is sampled.
- **Next-word acceptance:** `s_ready` returns 1 in the cycle after the final handshake of a word. The loader never accepts a byte while `mem_valid`=1.
- **Throughput:** with `mem_ready` asserted one cycle after `mem_valid`, one word costs 4 byte cycles + 2 cycles, plus 2 more with verify.
- **Release:** `cpu_hold` falls and `done` rises together, one edge after the last handshake.

## Configuration
- `PROG_LOADER_VERIFY_EN`:
  - Defined: the VERIFY state exists and performs a read-back after every write; a mismatch ends the load in ERROR.
  - Undefined: no VERIFY state, `mem_rdata` is unused and `error` is tied to 0.

## Structure
- Shared package `prog_loader_pkg`:
  - state enum `loader_state_t`;
  - constants `WSTRB_WORD` = 4'b1111 and `WSTRB_NONE` = 4'b0000.
- Sub-module `byte_packer`:
  - byte-lane shift/select plus a 2-bit lane counter;
  - outputs the 32-bit word and a one-cycle `word_valid` pulse;
  - has a clear input driven by the FSM.
- The top level holds the FSM, the address/word counters and the handshake logic.

## Test plan
- **Basic load:** WORD_COUNT=4; bytes 13 00 00 00 ×3 then 6F 00 00 00; RAM `mem_ready` one cycle after `mem_valid`.
  - Required: writes 0x0,0x4,0x8,0xC with 00000013 ×3 and 0000006F, all with `wstrb` 1111.
  - Then `done`=1, `cpu_hold`=0, `bus_sel`=0.
- **Stalled RAM:** `mem_ready` held off 5 cycles.
  - Required: `mem_valid`/`mem_addr`/`mem_wdata` unchanged for all 5 cycles and `s_ready`=0 throughout.
- **Stream gaps:** bytes 78,56,34,12 with 3 idle cycles between each.
  - Required: a single write of 12345678.
- **Reset mid-load:** `reset` pulsed after 2 bytes of word 1, then a full restart.
  - Required: all outputs at reset values the cycle after `reset`; the first write of the restart goes to ADDR_BASE.
- **Address wrap:** ADDR_BASE=FFFF_FFF8, WORD_COUNT=3.
  - Required: addresses FFFFFFF8, FFFFFFFC, 00000000.
- **Verify mismatch:** `PROG_LOADER_VERIFY_EN` defined; RAM model returns DEADBEEF on the read-back of word 1.
  - Required: `error`=1, `done`=0, `cpu_hold`=1, and no further `mem_valid`.
